// File: rtl/tlc_pkg.sv
// Shared phase/direction encodings and lamp decode for the intersection phase controller.
// FLASH (7) is reachable only in builds with TLC_NIGHT_FLASH_EN defined; otherwise it is illegal.
package tlc_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  // A direction shows red unless it owns green or yellow; flash_on drives the night blink.
  function automatic lamps_t decode_lamps(input phase_e p, input logic flash_on);
    lamps_t l;
    l        = '0;
    l.ns_red = 1'b1;
    l.ew_red = 1'b1;
    case (p)
      NS_GREEN:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
      NS_YELLOW: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
      EW_GREEN:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
      EW_YELLOW: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
      PED_WALK:  l.walk = 1'b1;
      FLASH: begin
        l.ns_red    = 1'b0;
        l.ns_yellow = flash_on;
        l.ew_red    = flash_on;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_controller_if.sv
// Control/lamp bundle between the intersection controller (slave) and whoever drives it (master).
// night_mode exists only when TLC_NIGHT_FLASH_EN is defined.
interface intersection_phase_controller_if
  import tlc_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic               enable;
  logic               tick;
  logic               ped_req;
`ifdef TLC_NIGHT_FLASH_EN
  logic               night_mode;
`endif
  logic               ped_ack;
  logic               walk;
  logic               ns_red;
  logic               ns_yellow;
  logic               ns_green;
  logic               ew_red;
  logic               ew_yellow;
  logic               ew_green;
  logic [PHASE_W-1:0] phase;
  logic [CNT_W-1:0]   remain;

  modport master (
`ifdef TLC_NIGHT_FLASH_EN
    output night_mode,
`endif
    output enable, tick, ped_req,
    input  ped_ack, walk, ns_red, ns_yellow, ns_green,
    input  ew_red, ew_yellow, ew_green, phase, remain
  );

  modport slave (
`ifdef TLC_NIGHT_FLASH_EN
    input  night_mode,
`endif
    input  enable, tick, ped_req,
    output ped_ack, walk, ns_red, ns_yellow, ns_green,
    output ew_red, ew_yellow, ew_green, phase, remain
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; counts only on enable&&tick and stops at zero.
// expired marks the advancing cycle on which the current phase ends.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remain,
  output logic             expired
);

  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] remain_d;

  // A load (phase change) takes priority over counting, even with the timebase gated off.
  always_comb begin
    remain_d = remain_q;
    if (load) begin
      remain_d = load_val;
    end else if (enable && tick && (remain_q != '0)) begin
      remain_d = remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain_q <= RST_VAL;
    end else begin
      remain_q <= remain_d;
    end
  end

  assign remain  = remain_q;
  assign expired = (remain_q == '0) && enable && tick;

endmodule

// File: rtl/intersection_phase_controller.sv
// Two-direction intersection sequencer with all-red clearance and latched pedestrian WALK service.
// Define TLC_NIGHT_FLASH_EN to add the night_mode input and the FLASH blinking state.
module intersection_phase_controller
  import tlc_pkg::*;
#(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10,
  parameter int CNT_W        = 8
) (
  input logic                           clk,
  input logic                           reset,
  intersection_phase_controller_if.slave bus
);

  phase_e           state_q, state_d;
  dir_e             next_dir_q, next_dir_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;
  lamps_t           lamps_q, lamps_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] remain;
  logic             expired;
  logic             enter_walk;
  logic             accept;
`ifdef TLC_NIGHT_FLASH_EN
  logic             flash_q, flash_d;
  logic             adv;
  assign adv = bus.enable & bus.tick;
`endif

  function automatic logic [CNT_W-1:0] ticks_m1(input phase_e p);
    case (p)
      NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_TICKS - 1);
      ALLRED_A, ALLRED_B:   return CNT_W'(ALLRED_TICKS - 1);
      PED_WALK:             return CNT_W'(WALK_TICKS - 1);
      default:              return '0;
    endcase
  endfunction

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_TICKS - 1))
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (bus.enable),
    .tick    (bus.tick),
    .load    (load),
    .load_val(load_val),
    .remain  (remain),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
`ifdef TLC_NIGHT_FLASH_EN
    flash_d    = flash_q;
    if (adv && bus.night_mode) begin
      state_d = FLASH;
      flash_d = (state_q == FLASH) ? ~flash_q : 1'b1;
    end else
`endif
    case (state_q)
      NS_GREEN:  if (expired) state_d = NS_YELLOW;
      NS_YELLOW: if (expired) state_d = ALLRED_A;
      ALLRED_A: if (expired) begin
        state_d    = pending_q ? PED_WALK : EW_GREEN;
        next_dir_d = DIR_EW;
      end
      EW_GREEN:  if (expired) state_d = EW_YELLOW;
      EW_YELLOW: if (expired) state_d = ALLRED_B;
      ALLRED_B: if (expired) begin
        state_d    = pending_q ? PED_WALK : NS_GREEN;
        next_dir_d = DIR_NS;
      end
      PED_WALK:  if (expired) state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
      FLASH:     if (adv) state_d = ALLRED_B;
`endif
      default:   state_d = ALLRED_B;
    endcase

    // Every transition changes the state, so a state change is exactly a timer reload.
    load     = (state_d != state_q);
    load_val = ticks_m1(state_d);

    // Entering WALK serves the latched request and beats a same-cycle new press.
    enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
    accept     = bus.ped_req && !pending_q && (state_q != PED_WALK) && !enter_walk;
    pending_d  = enter_walk ? 1'b0 : (pending_q | accept);
    ack_d      = accept;

`ifdef TLC_NIGHT_FLASH_EN
    lamps_d = decode_lamps(state_d, flash_d);
`else
    lamps_d = decode_lamps(state_d, 1'b0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ALLRED_B;
      next_dir_q <= DIR_NS;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      lamps_q    <= decode_lamps(ALLRED_B, 1'b0);
`ifdef TLC_NIGHT_FLASH_EN
      flash_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      lamps_q    <= lamps_d;
`ifdef TLC_NIGHT_FLASH_EN
      flash_q    <= flash_d;
`endif
    end
  end

  assign bus.phase     = state_q;
  assign bus.remain    = remain;
  assign bus.ped_ack   = ack_q;
  assign bus.walk      = lamps_q.walk;
  assign bus.ns_red    = lamps_q.ns_red;
  assign bus.ns_yellow = lamps_q.ns_yellow;
  assign bus.ns_green  = lamps_q.ns_green;
  assign bus.ew_red    = lamps_q.ew_red;
  assign bus.ew_yellow = lamps_q.ew_yellow;
  assign bus.ew_green  = lamps_q.ew_green;

endmodule

// File: doc/intersection_phase_controller.md
Name: intersection_phase_controller

Overview:
- Sequences a two-direction intersection: north-south (NS) and east-west (EW) light sets.
- Each phase runs for a parameterised number of timebase ticks.
- An all-red clearance interval separates every change of right-of-way.
- Pedestrian requests are latched and served with an all-red WALK phase; sits above the per-direction light drivers and owns all phase timing.

Parameters:
- GREEN_TICKS, 20, ticks per green phase (>=1).
- YELLOW_TICKS, 4, ticks per yellow phase (>=1).
- ALLRED_TICKS, 2, ticks per all-red clearance (>=1).
- WALK_TICKS, 10, ticks per pedestrian walk phase (>=1).
- CNT_W, 8, phase timer width; every *_TICKS value must be <= 2^CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run gate; low freezes state and timer.
- tick  in  1  one-cycle timebase strobe.
- ped_req  in  1  pedestrian button, level or pulse.
- ped_ack  out  1  one-cycle pulse: request accepted.
- walk  out  1  pedestrian walk lamp.
- ns_red / ns_yellow / ns_green  out  1 each  NS lamps.
- ew_red / ew_yellow / ew_green  out  1 each  EW lamps.
- phase  out  3  current state encoding.
- remain  out  CNT_W  ticks left in current phase minus one.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- States (3-bit): NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6; 7 is illegal.
- Reset:
  - state=ALLRED_B, remain=ALLRED_TICKS-1, pending=0, next_dir=NS, ped_ack=0.
  - Resulting outputs: ns_red=ew_red=1, all other lamps 0, walk=0.
- Advance: the timer moves only on a cycle where enable&&tick.
  - If remain!=0, remain decrements.
  - If remain==0, the state transitions on that clock edge and remain loads the new state's TICKS-1.
- Transitions:
  - NS_GREEN -> NS_YELLOW -> ALLRED_A.
  - ALLRED_A -> PED_WALK if pending, else EW_GREEN.
  - EW_GREEN -> EW_YELLOW -> ALLRED_B.
  - ALLRED_B -> PED_WALK if pending, else NS_GREEN.
  - PED_WALK -> NS_GREEN or EW_GREEN per next_dir.
- next_dir: set to EW on leaving ALLRED_A, to NS on leaving ALLRED_B.
- Illegal state: next edge goes to ALLRED_B with remain=ALLRED_TICKS-1.
- Lamps are decoded from the state register only; there is no combinational path from any input to any lamp.
  - A direction's red is 1 unless that direction is in GREEN or YELLOW.
  - walk=1 only in PED_WALK.
- Pedestrian handshake:
  - ped_req sampled high while pending==0 and state!=PED_WALK sets pending and pulses ped_ack for exactly one cycle on the next cycle.
  - Requests while pending==1 or in PED_WALK are dropped with no ack.
  - pending clears on entry to PED_WALK.
  - If the ped_req sample and the entry to PED_WALK fall on the same cycle, entry wins and the request is dropped.
- enable low: state, remain and pending are held; ped_req is still latched and acked.
- Reset mid-phase: immediate return to reset values; a pending request is lost.
- Lamp period with no pedestrian requests is 2*(GREEN+YELLOW+ALLRED) ticks.

Optional Feature:
- Macro TLC_NIGHT_FLASH_EN.
- When defined, adds input night_mode (1 bit) and state FLASH=7.
  - A tick (enable high) with night_mode=1 moves any state to FLASH.
  - In FLASH, ns_yellow and ew_red toggle on every tick, starting at 1; all other lamps and walk are 0.
  - ped_req is still latched and acked.
  - The first tick with night_mode=0 goes to ALLRED_B with remain=ALLRED_TICKS-1.
- When undefined: the port is absent, FLASH is illegal and recovers as above, and behaviour is identical to the base spec.

Decomposition:
- Package tlc_pkg: phase encodings (NS_GREEN..PED_WALK, FLASH), 3-bit phase width, direction enum (NS/EW).
- One sub-module phase_timer: loadable down-counter with tick/enable gating; takes a load value and outputs remain and an expired flag (remain==0 && enable && tick).

Test Plan:
Base setup for tests 1-4: GREEN=3, YELLOW=2, ALLRED=1, WALK=2; tick=enable=1 every cycle; reset released before cycle 0.
1. No ped_req -> phase sequence:
   - ALLRED_B at cycle 0; NS_GREEN cycles 1-3; NS_YELLOW 4-5; ALLRED_A 6.
   - EW_GREEN 7-9; EW_YELLOW 10-11; ALLRED_B 12; NS_GREEN 13.
   - At no cycle are a green or yellow lamp lit in both directions at once.
2. Single ped_req pulse at cycle 2:
   - ped_ack=1 at cycle 3 only.
   - PED_WALK with walk=1 at cycles 7-8, then EW_GREEN at cycle 9.
3. ped_req held high for cycles 2-20:
   - exactly one ack at cycle 3.
   - After walk ends at cycle 8, a new request is latched with ack at cycle 10.
   - Next walk runs at ALLRED_B+1.
4. enable=0 during cycles 2-5 -> NS_GREEN holds with remain=1 throughout; the sequence resumes shifted by 4 cycles.
5. Assert reset while in EW_YELLOW with pending=1 -> outputs return to all-red with walk=0 immediately; pending is cleared; NS_GREEN follows after 1 tick.
6. With TLC_NIGHT_FLASH_EN, night_mode=1 at cycle 5:
   - FLASH from cycle 6, with ns_yellow pattern 1,0,1,0.
   - night_mode=0 then gives ALLRED_B for 1 tick, then NS_GREEN.
